// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - shared ALU opcode definitions for the register/ALU pipeline
package reg_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/reg_alu_pipe_if.sv
// rtl/reg_alu_pipe_if.sv - issue and result handshake bundle for reg_alu_pipe
interface reg_alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic             src_sel;
  logic [2:0]       op;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_zero;

  modport master (
    output in_valid, src_sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_zero
  );

  modport slave (
    input  in_valid, src_sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_zero
  );
endinterface

// File: rtl/reg_alu_pipe_alu.sv
// rtl/reg_alu_pipe_alu.sv - combinational ALU core (alu_core)
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0] sum;

  always_comb begin
    result = '0;
    cout   = 1'b0;
    sum    = '0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OP_SUB: begin
        // carry out of a + ~b + 1 doubles as the unsigned a >= b flag
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result[0] = $signed(a) < $signed(b);
      OP_SLL: result = a << b[SW-1:0];
      OP_SRL: result = a >> b[SW-1:0];
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - register file with two-stage EX/WB ALU pipeline and result handshake
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  reg_alu_pipe_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] rf [DEPTH];

  logic             ex_valid;
  logic             ex_src;
  alu_op_e          ex_op;
  logic [AW-1:0]    ex_wr;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [WIDTH-1:0] ex_din;

  logic             wb_valid;
  logic [WIDTH-1:0] wb_data;
  logic             wb_cout;
  logic             wb_zero;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH-1:0] ex_result;
  logic             ex_cout;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             xfer;
  logic             issue;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (ex_a),
    .b      (ex_b),
    .op     (ex_op),
    .result (alu_res),
    .cout   (alu_cout)
  );

  assign ex_result = ex_src ? alu_res : ex_din;
  assign ex_cout   = ex_src & alu_cout;

  assign xfer         = ex_valid && (!wb_valid || bus.out_ready);
  assign bus.in_ready = !ex_valid || xfer;
  assign issue        = bus.in_valid && bus.in_ready;

  // EX result bypasses the file so dependent ops issue back-to-back
  assign opa = (ex_valid && bus.rd_addr_a == ex_wr) ? ex_result : rf[bus.rd_addr_a];
  assign opb = (ex_valid && bus.rd_addr_b == ex_wr) ? ex_result : rf[bus.rd_addr_b];

  assign bus.out_valid = wb_valid;
  assign bus.out_data  = wb_data;
  assign bus.out_cout  = wb_cout;
  assign bus.out_zero  = wb_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (xfer) begin
      rf[ex_wr] <= ex_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_src   <= 1'b0;
      ex_op    <= OP_ADD;
      ex_wr    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_din   <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_cout  <= 1'b0;
      wb_zero  <= 1'b0;
    end else begin
      if (xfer) begin
        wb_valid <= 1'b1;
        wb_data  <= ex_result;
        wb_cout  <= ex_cout;
        wb_zero  <= (ex_result == '0);
      end else if (wb_valid && bus.out_ready) begin
        wb_valid <= 1'b0;
      end

      if (issue) begin
        ex_valid <= 1'b1;
        ex_src   <= bus.src_sel;
        ex_op    <= alu_op_e'(bus.op);
        ex_wr    <= bus.wr_addr;
        ex_a     <= opa;
        ex_b     <= opb;
        ex_din   <= bus.d_in;
      end else if (xfer) begin
        ex_valid <= 1'b0;
      end
    end
  end
endmodule
